// File: rtl/mux_rr_arb_pkg.sv
// Shared definitions for the parametrised mux/arbiter family.
// Provides the arbitration mode constants and the width helpers used to size
// channel-index fields. No ports.
package mux_rr_arb_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Channel-index width; never narrower than one bit.
  function automatic int ch_width(input int ch_num);
    return (clog2(ch_num) < 1) ? 1 : clog2(ch_num);
  endfunction

endpackage

// File: rtl/mux_rr_arb_if.sv
// Handshake bundle between CH_NUM producers, the arbitrating mux and one
// consumer.
//   din_valid  [CH_NUM]            per-channel valid (producer -> mux)
//   din_data   [CH_NUM*DATA_SIZE]  flattened channel data, ch i at [i*DATA_SIZE +: DATA_SIZE]
//   din_ready  [CH_NUM]            per-channel ready, one-hot or zero (mux -> producer)
//   dout_valid                     output word valid (mux -> consumer)
//   dout_data  [DATA_SIZE]         selected word
//   dout_ch    [CH_W]              source channel of dout_data
//   dout_ready                     consumer ready (consumer -> mux)
// Modport slave is the mux side; master is the producer/consumer side.
interface mux_rr_arb_if #(
  parameter int DATA_SIZE = 4,
  parameter int CH_NUM    = 4
) ();
  localparam int CH_W = mux_rr_arb_pkg::ch_width(CH_NUM);

  logic [CH_NUM-1:0]           din_valid;
  logic [CH_NUM*DATA_SIZE-1:0] din_data;
  logic [CH_NUM-1:0]           din_ready;
  logic                        dout_valid;
  logic [DATA_SIZE-1:0]        dout_data;
  logic [CH_W-1:0]             dout_ch;
  logic                        dout_ready;

  modport slave (
    input  din_valid, din_data, dout_ready,
    output din_ready, dout_valid, dout_data, dout_ch
  );

  modport master (
    output din_valid, din_data, dout_ready,
    input  din_ready, dout_valid, dout_data, dout_ch
  );
endinterface

// File: rtl/mux_rr_arb_rr_arbiter.sv
// Round-robin / fixed-priority arbiter.
//   clk, rst  clock and synchronous active-high reset
//   req       per-channel request
//   en        grant enable (output stage can accept a word)
//   gnt       one-hot grant, zero when en is low or nothing requests
//   gnt_idx   index of the granted channel
//   any_gnt   a grant is issued this cycle
// In round-robin mode the search starts one past the last granted channel
// and wraps to 0 after CH_NUM-1; the pointer moves only when a grant is
// actually issued.
module rr_arbiter
  import mux_rr_arb_pkg::*;
#(
  parameter int  CH_NUM = 4,
  parameter int  MODE   = MODE_RR,
  localparam int CH_W   = ch_width(CH_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_NUM-1:0] req,
  input  logic              en,
  output logic [CH_NUM-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              any_gnt
);

  logic [CH_W-1:0] last_gnt;
  logic [CH_W-1:0] cand_idx;
  int              cand;

  always_comb begin
    gnt_idx  = '0;
    any_gnt  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if (MODE == MODE_FIXED) begin
      // Scan downwards so the lowest requesting index is the last one kept.
      for (int i = CH_NUM - 1; i >= 0; i--) begin
        if (req[CH_W'(i)]) begin
          gnt_idx = CH_W'(i);
          any_gnt = 1'b1;
        end
      end
    end else begin
      // Scan the offsets furthest-first so the nearest successor of
      // last_gnt wins; the sum stays below 2*CH_NUM, so one subtraction wraps.
      for (int k = CH_NUM; k >= 1; k--) begin
        cand = int'(last_gnt) + k;
        if (cand >= CH_NUM) cand = cand - CH_NUM;
        cand_idx = CH_W'(cand);
        if (req[cand_idx]) begin
          gnt_idx = cand_idx;
          any_gnt = 1'b1;
        end
      end
    end
    if (!en) any_gnt = 1'b0;
    gnt = any_gnt ? (CH_NUM'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= CH_W'(CH_NUM - 1);
    end else if (any_gnt && (MODE == MODE_RR)) begin
      last_gnt <= gnt_idx;
    end
  end

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel arbitrating mux with a single registered output stage.
//   clk, rst  clock and synchronous active-high reset
//   bus       mux_rr_arb_if.slave: per-channel valid/data/ready inputs and
//             the tagged output word (dout_valid/dout_data/dout_ch/dout_ready)
// The output register accepts a new word whenever it is empty or being
// drained in the same cycle, giving one word per cycle at full throughput.
// Outputs come only from registers, so there is no din_* -> dout_* path.
module mux_rr_arb
  import mux_rr_arb_pkg::*;
#(
  parameter int  DATA_SIZE = 4,
  parameter int  CH_NUM    = 4,
  parameter int  MODE      = MODE_RR,
  localparam int CH_W      = ch_width(CH_NUM)
) (
  input logic          clk,
  input logic          rst,
  mux_rr_arb_if.slave  bus
);

  logic                 out_free;
  logic [CH_NUM-1:0]    gnt;
  logic [CH_W-1:0]      gnt_idx;
  logic                 any_gnt;
  logic [DATA_SIZE-1:0] data_p0;

  logic                 vld_p1;
  logic [DATA_SIZE-1:0] data_p1;
  logic [CH_W-1:0]      ch_p1;

  assign out_free = !vld_p1 || bus.dout_ready;

  rr_arbiter #(
    .CH_NUM (CH_NUM),
    .MODE   (MODE)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.din_valid),
    .en      (out_free),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign bus.din_ready = gnt;

  // Stage p0: select the granted channel's word.
  always_comb begin
    data_p0 = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (gnt_idx == CH_W'(i)) data_p0 = bus.din_data[i*DATA_SIZE +: DATA_SIZE];
    end
  end

  // Stage p1: output register; a new word overwrites one leaving this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= '0;
    end else if (any_gnt) begin
      vld_p1  <= 1'b1;
      data_p1 <= data_p0;
      ch_p1   <= gnt_idx;
    end else if (bus.dout_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.dout_valid = vld_p1;
  assign bus.dout_data  = data_p1;
  assign bus.dout_ch    = ch_p1;

endmodule

// File: tb/tb_mux_rr_arb.sv
// Bench for mux_rr_arb: three instances (RR 4x4, fixed 4x4, RR 3 channels
// of 8 bits) checked cycle by cycle against a transaction-level model.
module tb_mux_rr_arb;

  logic clk;
  logic rst;

  mux_rr_arb_if #(.DATA_SIZE(4), .CH_NUM(4)) ia ();
  mux_rr_arb_if #(.DATA_SIZE(4), .CH_NUM(4)) ib ();
  mux_rr_arb_if #(.DATA_SIZE(8), .CH_NUM(3)) ic ();

  mux_rr_arb #(.DATA_SIZE(4), .CH_NUM(4), .MODE(0)) dut_rr  (.clk(clk), .rst(rst), .bus(ia));
  mux_rr_arb #(.DATA_SIZE(4), .CH_NUM(4), .MODE(1)) dut_fx  (.clk(clk), .rst(rst), .bus(ib));
  mux_rr_arb #(.DATA_SIZE(8), .CH_NUM(3), .MODE(0)) dut_ch3 (.clk(clk), .rst(rst), .bus(ic));

  int checks   = 0;
  int failures = 0;

  // Per-instance configuration and model state.
  int n_ch [3] = '{4, 4, 3};
  int dw   [3] = '{4, 4, 8};
  int mode [3] = '{0, 1, 0};
  int m_vld[3];
  int m_dat[3];
  int m_ch [3];
  int m_last[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner among the valid channels v for instance d, or -1 if none.
  function automatic int pick(input int d, input logic [15:0] v);
    if (mode[d] == 1) begin
      for (int i = 0; i < n_ch[d]; i++) if (v[i]) return i;
    end else begin
      for (int k = 1; k <= n_ch[d]; k++) begin
        int idx;
        idx = (m_last[d] + k) % n_ch[d];
        if (v[idx]) return idx;
      end
    end
    return -1;
  endfunction

  task automatic zero_inputs();
    ia.din_valid = '0; ia.din_data = '0; ia.dout_ready = 1'b0;
    ib.din_valid = '0; ib.din_data = '0; ib.dout_ready = 1'b0;
    ic.din_valid = '0; ic.din_data = '0; ic.dout_ready = 1'b0;
  endtask

  task automatic do_reset();
    int ov, od, oc;
    @(negedge clk);
    zero_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      m_vld[d] = 0; m_dat[d] = 0; m_ch[d] = 0; m_last[d] = n_ch[d] - 1;
      case (d)
        0: begin ov = int'(ia.dout_valid); od = int'(ia.dout_data); oc = int'(ia.dout_ch); end
        1: begin ov = int'(ib.dout_valid); od = int'(ib.dout_data); oc = int'(ib.dout_ch); end
        default: begin ov = int'(ic.dout_valid); od = int'(ic.dout_data); oc = int'(ic.dout_ch); end
      endcase
      checks++;
      if (ov !== 0 || od !== 0 || oc !== 0) begin
        failures++;
        $display("FAIL reset_state dut%0d got vld=%0d data=%0h ch=%0d exp 0/0/0", d, ov, od, oc);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock on instance d: drive inputs, check ready, then check outputs.
  task automatic step(input string tag, input int d, input logic [15:0] v_in,
                      input logic [63:0] dat, input bit rdy);
    logic [15:0] v, exp_rdy, act_rdy;
    int g, ov, od, oc;
    v = v_in & ((16'd1 << n_ch[d]) - 16'd1);
    @(negedge clk);
    case (d)
      0: begin ia.din_valid = v[3:0]; ia.din_data = dat[15:0]; ia.dout_ready = rdy; end
      1: begin ib.din_valid = v[3:0]; ib.din_data = dat[15:0]; ib.dout_ready = rdy; end
      default: begin ic.din_valid = v[2:0]; ic.din_data = dat[23:0]; ic.dout_ready = rdy; end
    endcase
    #1;
    g = (m_vld[d] == 0 || rdy) ? pick(d, v) : -1;
    exp_rdy = (g >= 0) ? (16'd1 << g) : 16'd0;
    case (d)
      0: act_rdy = 16'(ia.din_ready);
      1: act_rdy = 16'(ib.din_ready);
      default: act_rdy = 16'(ic.din_ready);
    endcase
    checks++;
    if (act_rdy !== exp_rdy) begin
      failures++;
      $display("FAIL %s din_ready dut%0d got=%h exp=%h", tag, d, act_rdy, exp_rdy);
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m_vld[d] = 1;
      m_dat[d] = int'((dat >> (g * dw[d])) & ((64'd1 << dw[d]) - 64'd1));
      m_ch[d]  = g;
      if (mode[d] == 0) m_last[d] = g;
    end else if (rdy) begin
      m_vld[d] = 0;
    end
    case (d)
      0: begin ov = int'(ia.dout_valid); od = int'(ia.dout_data); oc = int'(ia.dout_ch); end
      1: begin ov = int'(ib.dout_valid); od = int'(ib.dout_data); oc = int'(ib.dout_ch); end
      default: begin ov = int'(ic.dout_valid); od = int'(ic.dout_data); oc = int'(ic.dout_ch); end
    endcase
    checks++;
    if (ov !== m_vld[d]) begin
      failures++;
      $display("FAIL %s dout_valid dut%0d got=%0d exp=%0d", tag, d, ov, m_vld[d]);
    end
    checks++;
    if (od !== m_dat[d]) begin
      failures++;
      $display("FAIL %s dout_data dut%0d got=%0h exp=%0h", tag, d, od, m_dat[d]);
    end
    checks++;
    if (oc !== m_ch[d]) begin
      failures++;
      $display("FAIL %s dout_ch dut%0d got=%0d exp=%0d", tag, d, oc, m_ch[d]);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_rr_all();
    do_reset();
    for (int i = 0; i < 9; i++) step("rr_all", 0, 16'hF, 64'h4321, 1'b1);
  endtask

  task automatic test_rr_sparse();
    do_reset();
    for (int i = 0; i < 6; i++) step("rr_sparse", 0, 16'b1010, 64'hB0A0, 1'b1);
  endtask

  task automatic test_fixed();
    do_reset();
    for (int i = 0; i < 4; i++) step("fixed_all", 1, 16'hF, 64'h4321, 1'b1);
    for (int i = 0; i < 2; i++) step("fixed_drop0", 1, 16'hE, 64'h4321, 1'b1);
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 3; i++) step("bp_fill", 0, 16'hF, 64'h4321, 1'b1);
    for (int i = 0; i < 3; i++) step("bp_stall", 0, 16'hF, 64'h4321, 1'b0);
    step("bp_release", 0, 16'hF, 64'h4321, 1'b1);
    step("bp_release", 0, 16'hF, 64'h4321, 1'b1);
  endtask

  task automatic test_reset_midstream();
    do_reset();
    step("mid_load", 0, 16'b0001, 64'h0005, 1'b0);
    step("mid_stall", 0, 16'hF, 64'h4321, 1'b0);
    do_reset();
    step("mid_after", 0, 16'b0110, 64'h0770, 1'b1);
  endtask

  task automatic test_wrap3();
    do_reset();
    for (int i = 0; i < 7; i++) step("wrap3", 2, 16'h7, 64'h332211, 1'b1);
  endtask

  task automatic test_random();
    do_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 150; i++) begin
        step("random", d, 16'($urandom), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    zero_inputs();
    test_reset();
    test_rr_all();
    test_rr_sparse();
    test_fixed();
    test_backpressure();
    test_reset_midstream();
    test_wrap3();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
